// File: rtl/seg_pkg.sv
// Shared constants and types for the multiplexed seven-segment scan decoder.
// Segment patterns are active-low and written g..a (bit6 = g, bit0 = a).
package seg_pkg;

  localparam logic [3:0] BLANK_CODE = 4'hF;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HELD   = 2'd2
  } scan_state_e;

endpackage

// File: rtl/seg_pattern_decode.sv
// Combinational seven-segment pattern to BCD decoder; the single decode table.
// Blank and illegal patterns both report BLANK_CODE as the value.
module seg_pattern_decode
  import seg_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] value,
  output logic       blank,
  output logic       illegal
);

  // Pattern lookup; anything not in the table is flagged illegal.
  always_comb begin
    value   = BLANK_CODE;
    blank   = 1'b0;
    illegal = 1'b0;
    case (seg)
      SEG_0:     value = 4'd0;
      SEG_1:     value = 4'd1;
      SEG_2:     value = 4'd2;
      SEG_3:     value = 4'd3;
      SEG_4:     value = 4'd4;
      SEG_5:     value = 4'd5;
      SEG_6:     value = 4'd6;
      SEG_7:     value = 4'd7;
      SEG_8:     value = 4'd8;
      SEG_9:     value = 4'd9;
      SEG_BLANK: blank = 1'b1;
      default:   illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// Samples a multiplexed seven-segment display bus, debounces each digit dwell,
// and commits the decoded digit into per-digit registered outputs.
module seg_scan_decoder
  import seg_pkg::*;
#(
  parameter int NUM_DIG    = 4,
  parameter int STABLE_CNT = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [6:0]             seg_in,
  input  logic [NUM_DIG-1:0]     dig_en_n,
  output logic [4*NUM_DIG-1:0]   bcd_out,
  output logic [NUM_DIG-1:0]     blank_out,
  output logic [NUM_DIG-1:0]     digit_valid,
  output logic                   frame_done,
  output logic                   err_pattern,
  output logic                   err_sel
);

  localparam int                 SMP_W    = 7 + NUM_DIG;
  localparam logic [3:0]         CNT_MAX  = 4'(STABLE_CNT);
  localparam logic [3:0]         CNT_LAST = 4'(STABLE_CNT - 1);
  localparam logic [NUM_DIG-1:0] ALL_SEEN = '1;
  localparam logic [NUM_DIG-1:0] ONE_SEL  = NUM_DIG'(1);

  logic [SMP_W-1:0]   in_s;
  logic [SMP_W-1:0]   smp_r;
  logic [3:0]         cnt_r;
  logic [NUM_DIG-1:0] mask_r;
  logic [NUM_DIG-1:0] sel_s;
  logic [NUM_DIG-1:0] commit_bits_s;
  logic               changed_s;
  logic               onehot_s;
  logic               commit_s;
  logic [3:0]         dec_value_s;
  logic               dec_blank_s;
  logic               dec_illegal_s;
  scan_state_e        state_r;
  scan_state_e        state_nxt_s;

  assign in_s      = {seg_in, dig_en_n};
  assign changed_s = (in_s != smp_r);
  assign sel_s     = ~smp_r[NUM_DIG-1:0];
  assign onehot_s  = (sel_s != '0) && ((sel_s & (sel_s - ONE_SEL)) == '0);
  assign commit_bits_s = (commit_s && onehot_s) ? sel_s : '0;

  seg_pattern_decode u_decode (
    .seg     (smp_r[SMP_W-1:NUM_DIG]),
    .value   (dec_value_s),
    .blank   (dec_blank_s),
    .illegal (dec_illegal_s)
  );

  // Input sampler and saturating stability counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      smp_r <= '1;
      cnt_r <= 4'd0;
    end else begin
      smp_r <= in_s;
      if (changed_s) begin
        cnt_r <= 4'd0;
      end else if (cnt_r != CNT_MAX) begin
        cnt_r <= cnt_r + 4'd1;
      end
    end
  end

  // Dwell state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next state; commit fires on the edge where the counter reaches STABLE_CNT.
  always_comb begin
    state_nxt_s = state_r;
    commit_s    = 1'b0;
    if (changed_s) begin
      state_nxt_s = (&dig_en_n) ? ST_IDLE : ST_SETTLE;
    end else begin
      case (state_r)
        ST_IDLE:   state_nxt_s = ST_IDLE;
        ST_SETTLE: begin
          if (cnt_r == CNT_LAST) begin
            state_nxt_s = ST_HELD;
            commit_s    = 1'b1;
          end else begin
            state_nxt_s = ST_SETTLE;
          end
        end
        ST_HELD:   state_nxt_s = ST_HELD;
        default:   state_nxt_s = ST_IDLE;
      endcase
    end
  end

  // Digit outputs, error pulses and frame tracking; a full mask reports one
  // edge late so a commit landing on that edge starts the next frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcd_out     <= {NUM_DIG{BLANK_CODE}};
      blank_out   <= '1;
      digit_valid <= '0;
      frame_done  <= 1'b0;
      err_pattern <= 1'b0;
      err_sel     <= 1'b0;
      mask_r      <= '0;
    end else begin
      frame_done  <= (mask_r == ALL_SEEN);
      err_pattern <= commit_s && onehot_s && dec_illegal_s;
      err_sel     <= commit_s && !onehot_s;
      if (mask_r == ALL_SEEN) begin
        mask_r <= commit_bits_s;
      end else begin
        mask_r <= mask_r | commit_bits_s;
      end
      for (int i = 0; i < NUM_DIG; i++) begin
        if (commit_bits_s[i]) begin
          bcd_out[4*i +: 4] <= dec_value_s;
          blank_out[i]      <= dec_blank_s;
          digit_valid[i]    <= !dec_illegal_s;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Self-checking bench for seg_scan_decoder: directed scenarios plus random
// dwells, compared every cycle against a run-length reference model.
module tb_seg_scan_decoder;

  localparam int ND = 4;
  localparam int SC = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  seg_in;
  logic [3:0]  dig_en_n;
  logic [15:0] bcd_out;
  logic [3:0]  blank_out;
  logic [3:0]  digit_valid;
  logic        frame_done;
  logic        err_pattern;
  logic        err_sel;

  int errors = 0;
  int checks = 0;
  int frame_cnt = 0;
  int errp_cnt = 0;
  int errs_cnt = 0;

  logic [6:0] pat_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000};

  // reference model state
  logic [15:0] m_bcd;
  logic [3:0]  m_blank;
  logic [3:0]  m_valid;
  logic [3:0]  m_seen;
  logic        m_full;
  logic        m_frame;
  logic        m_errp;
  logic        m_errs;
  logic [10:0] m_prev;
  int          m_run;

  always #5 clk = ~clk;

  seg_scan_decoder #(.NUM_DIG(ND), .STABLE_CNT(SC)) dut (
    .clk         (clk),
    .rst         (rst),
    .seg_in      (seg_in),
    .dig_en_n    (dig_en_n),
    .bcd_out     (bcd_out),
    .blank_out   (blank_out),
    .digit_valid (digit_valid),
    .frame_done  (frame_done),
    .err_pattern (err_pattern),
    .err_sel     (err_sel)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string where);
    chk({where, ".bcd"},   32'(bcd_out),     32'(m_bcd));
    chk({where, ".blank"}, 32'(blank_out),   32'(m_blank));
    chk({where, ".valid"}, 32'(digit_valid), 32'(m_valid));
    chk({where, ".frame"}, 32'(frame_done),  32'(m_frame));
    chk({where, ".errp"},  32'(err_pattern), 32'(m_errp));
    chk({where, ".errs"},  32'(err_sel),     32'(m_errs));
  endtask

  task automatic model_reset();
    m_bcd   = 16'hFFFF;
    m_blank = 4'hF;
    m_valid = 4'h0;
    m_seen  = 4'h0;
    m_full  = 1'b0;
    m_frame = 1'b0;
    m_errp  = 1'b0;
    m_errs  = 1'b0;
    m_prev  = 11'h7FF;
    m_run   = 0;
  endtask

  task automatic ref_decode(input logic [6:0] s, output logic [3:0] v,
                            output logic blank, output logic illegal);
    v = 4'hF;
    blank = 1'b0;
    illegal = 1'b1;
    if (s == 7'h7F) begin
      blank = 1'b1;
      illegal = 1'b0;
    end else begin
      for (int k = 0; k < 10; k++) begin
        if (pat_tab[k] == s) begin
          v = 4'(k);
          illegal = 1'b0;
        end
      end
    end
  endtask

  // one clock edge of the model: a digit commits when its input has been held
  // for exactly SC+1 consecutive edges
  task automatic model_edge(input logic [6:0] seg, input logic [3:0] en);
    logic [10:0] x;
    logic [3:0]  bits;
    logic [3:0]  v;
    logic        bl;
    logic        il;
    int          zeros;
    int          idx;
    x = {seg, en};
    if (x == m_prev) m_run++;
    else m_run = 1;
    m_prev  = x;
    bits    = 4'h0;
    m_frame = m_full;
    m_errp  = 1'b0;
    m_errs  = 1'b0;
    if (m_run == SC + 1 && en != 4'hF) begin
      zeros = 0;
      idx = 0;
      for (int i = 0; i < ND; i++) begin
        if (!en[i]) begin
          zeros++;
          idx = i;
        end
      end
      if (zeros == 1) begin
        ref_decode(seg, v, bl, il);
        m_bcd[4*idx +: 4] = v;
        m_blank[idx] = bl;
        m_valid[idx] = !il;
        m_errp = il;
        bits[idx] = 1'b1;
      end else begin
        m_errs = 1'b1;
      end
    end
    if (m_full) m_seen = bits;
    else m_seen = m_seen | bits;
    m_full = (m_seen == 4'hF);
  endtask

  task automatic step(input logic [6:0] seg, input logic [3:0] en, input string tag);
    seg_in = seg;
    dig_en_n = en;
    @(posedge clk);
    model_edge(seg, en);
    @(negedge clk);
    check_all(tag);
    frame_cnt += int'(frame_done);
    errp_cnt  += int'(err_pattern);
    errs_cnt  += int'(err_sel);
  endtask

  task automatic dwell(input logic [6:0] seg, input logic [3:0] en, input int n, input string tag);
    for (int i = 0; i < n; i++) step(seg, en, tag);
  endtask

  task automatic do_reset(input logic [6:0] seg, input logic [3:0] en);
    seg_in = seg;
    dig_en_n = en;
    rst = 1'b1;
    #1;
    model_reset();
    check_all("rst");
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [15:0] saved_bcd;
    logic [6:0]  rs;
    logic [3:0]  re;
    int          k;

    // reset then idle
    do_reset(7'h7F, 4'hF);
    frame_cnt = 0; errp_cnt = 0; errs_cnt = 0;
    dwell(7'h7F, 4'hF, 20, "idle");
    chk("idle_bcd", 32'(bcd_out), 32'h0000FFFF);
    chk("idle_blank", 32'(blank_out), 32'hF);
    chk("idle_pulses", 32'(frame_cnt + errp_cnt + errs_cnt), 32'd0);

    // full scan 1,2,3,4
    frame_cnt = 0;
    dwell(7'b1111001, 4'b1110, 6, "scan0");
    dwell(7'b0100100, 4'b1101, 6, "scan1");
    dwell(7'b0110000, 4'b1011, 6, "scan2");
    dwell(7'b0011001, 4'b0111, 6, "scan3");
    chk("scan_bcd", 32'(bcd_out), 32'h00004321);
    chk("scan_valid", 32'(digit_valid), 32'hF);
    chk("scan_frames", 32'(frame_cnt), 32'd1);

    // glitch shorter than the stability window
    errp_cnt = 0; errs_cnt = 0;
    dwell(7'b0100100, 4'b1110, 3, "glitch_a");
    dwell(7'b1111001, 4'b1110, 6, "glitch_b");
    chk("glitch_digit0", 32'(bcd_out[3:0]), 32'd1);
    chk("glitch_err", 32'(errp_cnt + errs_cnt), 32'd0);

    // illegal pattern on digit 2, pulse on the fifth edge
    errp_cnt = 0;
    dwell(7'b0101010, 4'b1011, 4, "illegal_pre");
    step(7'b0101010, 4'b1011, "illegal_e5");
    chk("illegal_pulse_e5", 32'(err_pattern), 32'd1);
    step(7'b0101010, 4'b1011, "illegal_e6");
    chk("illegal_valid2", 32'(digit_valid[2]), 32'd0);
    chk("illegal_bcd2", 32'(bcd_out[11:8]), 32'hF);
    chk("illegal_count", 32'(errp_cnt), 32'd1);

    // multi-hot select
    saved_bcd = bcd_out;
    errs_cnt = 0;
    dwell(7'b0010010, 4'b1100, 6, "multihot");
    chk("multihot_bcd", 32'(bcd_out), 32'(saved_bcd));
    chk("multihot_count", 32'(errs_cnt), 32'd1);

    // reset in the middle of a digit-5 dwell on digit 1
    dwell(7'b0010010, 4'b1101, 3, "rstmid_pre");
    do_reset(7'b0010010, 4'b1101);
    dwell(7'b0010010, 4'b1101, 4, "rstmid_e1_4");
    chk("rstmid_no_commit", 32'(bcd_out[7:4]), 32'hF);
    step(7'b0010010, 4'b1101, "rstmid_e5");
    chk("rstmid_commit_e5", 32'(bcd_out[7:4]), 32'd5);
    step(7'b0010010, 4'b1101, "rstmid_e6");

    // random dwells against the model
    for (int n = 0; n < 120; n++) begin
      if ($urandom_range(0, 4) == 0) rs = 7'($urandom_range(0, 127));
      else begin
        k = $urandom_range(0, 10);
        rs = (k == 10) ? 7'h7F : pat_tab[k];
      end
      if ($urandom_range(0, 5) == 0) re = 4'($urandom_range(0, 15));
      else re = 4'hF ^ (4'b0001 << $urandom_range(0, 3));
      if ($urandom_range(0, 29) == 0) do_reset(rs, re);
      dwell(rs, re, $urandom_range(1, 7), "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
